// File: rtl/pwm_capture.sv
// ============================================================================
// Module   : pwm_capture
// Brief    : PWM receiver. Measures period (rise to rise) and high time
//            (rise to fall) in clk cycles, and flags a static input.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_capture #(
  parameter int          CNT_W   = 16,
  parameter int unsigned TIMEOUT = 32'h8000  // must be < 2^CNT_W - 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] period_cnt,
  output logic [CNT_W-1:0] high_cnt,
  output logic             meas_valid,
  output logic             stuck,
  output logic             stuck_level
);

  localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE_V     = CNT_W'(1);
  localparam logic [CNT_W-1:0] ONES_V    = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_HIGH  = 2'd1,
    S_LOW   = 2'd2,
    S_STUCK = 2'd3
  } state_e;

  state_e           state_q;
  logic             s1_q, s2_q, prev_q;
  logic [CNT_W-1:0] per_acc_q, high_acc_q, idle_acc_q, h_lat_q;
  logic [CNT_W-1:0] period_q, high_q;
  logic             valid_q, stuck_q, level_q;

  logic             rise, fall, timeout, enter_stuck;
  logic [CNT_W-1:0] per_inc, high_inc, idle_acc_d;

  // Edge detection on the synchronized input; only one can fire per cycle.
  assign rise     = s2_q & ~prev_q;
  assign fall     = ~s2_q & prev_q;
  assign timeout  = (idle_acc_q == TIMEOUT_V);
  assign per_inc  = (per_acc_q  == ONES_V) ? per_acc_q  : per_acc_q  + ONE_V;
  assign high_inc = (high_acc_q == ONES_V) ? high_acc_q : high_acc_q + ONE_V;

  // An edge in the same cycle as the timeout wins, so the stream is kept.
  assign enter_stuck = (state_q != S_STUCK) && timeout && !rise && !fall;

  // Cycles since the last edge, saturating at the timeout value.
  always_comb begin
    idle_acc_d = idle_acc_q;
    if (rise || fall) begin
      idle_acc_d = '0;
    end else if (!timeout) begin
      idle_acc_d = idle_acc_q + ONE_V;
    end
  end

  // Two-flop synchronizer plus a delayed copy for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      prev_q     <= 1'b0;
      idle_acc_q <= '0;
    end else begin
      s1_q       <= pwm_in;
      s2_q       <= s1_q;
      prev_q     <= s2_q;
      idle_acc_q <= idle_acc_d;
    end
  end

  // Measurement FSM: accumulators, latched high time and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      per_acc_q  <= '0;
      high_acc_q <= '0;
      h_lat_q    <= '0;
      period_q   <= '0;
      high_q     <= '0;
      valid_q    <= 1'b0;
      stuck_q    <= 1'b0;
      level_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (enter_stuck) begin
        // Report a static input once: period 0, high time all-ones or 0.
        state_q  <= S_STUCK;
        stuck_q  <= 1'b1;
        level_q  <= s2_q;
        high_q   <= s2_q ? ONES_V : '0;
        period_q <= '0;
        valid_q  <= 1'b1;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            // First rise only starts timing; there is no full period yet.
            if (rise) begin
              state_q    <= S_HIGH;
              per_acc_q  <= ONE_V;
              high_acc_q <= ONE_V;
            end
          end
          S_HIGH: begin
            per_acc_q <= per_inc;
            if (fall) begin
              state_q <= S_LOW;
              h_lat_q <= high_acc_q;
            end else begin
              high_acc_q <= high_inc;
            end
          end
          S_LOW: begin
            if (rise) begin
              state_q    <= S_HIGH;
              period_q   <= per_acc_q;
              high_q     <= h_lat_q;
              valid_q    <= 1'b1;
              per_acc_q  <= ONE_V;
              high_acc_q <= ONE_V;
            end else begin
              per_acc_q <= per_inc;
            end
          end
          S_STUCK: begin
            // Outputs hold; any edge leaves, without a report.
            if (rise) begin
              state_q    <= S_HIGH;
              stuck_q    <= 1'b0;
              per_acc_q  <= ONE_V;
              high_acc_q <= ONE_V;
            end else if (fall) begin
              state_q <= S_IDLE;
              stuck_q <= 1'b0;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign period_cnt  = period_q;
  assign high_cnt    = high_q;
  assign meas_valid  = valid_q;
  assign stuck       = stuck_q;
  assign stuck_level = level_q;

endmodule

`default_nettype wire

// File: tb/tb_pwm_capture.sv
// ============================================================================
// Module   : tb_pwm_capture
// Brief    : Self-checking bench for pwm_capture (directed vectors).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pwm_capture;

  // Shorter timeout keeps stuck tests quick; still above the longest
  // phase (4095 cycles) used in the waveform table.
  localparam int unsigned T_OUT = 32'h2000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pwm_in = 1'b0;
  logic [15:0] period_cnt, high_cnt;
  logic        meas_valid, stuck, stuck_level;

  pwm_capture #(.CNT_W(16), .TIMEOUT(T_OUT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pwm_in     (pwm_in),
    .period_cnt (period_cnt),
    .high_cnt   (high_cnt),
    .meas_valid (meas_valid),
    .stuck      (stuck),
    .stuck_level(stuck_level)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Report monitor: every meas_valid pulse is captured as {period, high}.
  logic [31:0] mq[$];
  int          pulses = 0;
  int          b2b = 0;
  logic        prev_v = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v = 1'b0;
    end else begin
      if (meas_valid) begin
        mq.push_back({period_cnt, high_cnt});
        pulses++;
        if (prev_v) b2b++;
      end
      prev_v = meas_valid;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic level, input int n);
    pwm_in = level;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic clear_mon();
    #1;
    mq.delete();
    pulses = 0;
  endtask

  typedef struct {
    int          hi;
    int          lo;
    int          reps;
    logic [15:0] exp_period;
    logic [15:0] exp_high;
  } vec_t;

  vec_t        vecs[5];
  logic [31:0] expq[$];

  initial begin
    vecs[0] = '{hi: 100,  lo: 3996, reps: 2, exp_period: 16'd4096, exp_high: 16'd100};
    vecs[1] = '{hi: 4095, lo: 1,    reps: 2, exp_period: 16'd4096, exp_high: 16'd4095};
    vecs[2] = '{hi: 1,    lo: 1,    reps: 4, exp_period: 16'd2,    exp_high: 16'd1};
    vecs[3] = '{hi: 5,    lo: 5,    reps: 2, exp_period: 16'd10,   exp_high: 16'd5};
    vecs[4] = '{hi: 64,   lo: 192,  reps: 2, exp_period: 16'd256,  exp_high: 16'd64};

    // ---- reset state ----
    repeat (3) @(negedge clk);
    #1;
    chk("rst_period", 32'(period_cnt), 32'h0);
    chk("rst_high", 32'(high_cnt), 32'h0);
    chk("rst_valid", 32'(meas_valid), 32'h0);
    chk("rst_stuck", 32'(stuck), 32'h0);
    chk("rst_level", 32'(stuck_level), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // ---- report latency: valid appears after the third sampling edge ----
    drive(1'b1, 4);
    drive(1'b0, 4);
    pwm_in = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk("lat_edge2_valid", 32'(meas_valid), 32'h0);
    @(posedge clk);
    #1 chk("lat_edge3_valid", 32'(meas_valid), 32'h1);
    chk("lat_period", 32'(period_cnt), 32'd8);
    chk("lat_high", 32'(high_cnt), 32'd4);
    @(posedge clk);
    #1 chk("lat_edge4_valid", 32'(meas_valid), 32'h0);
    @(negedge clk);

    // ---- table-driven continuous waveform ----
    do_reset();
    clear_mon();
    expq.delete();
    for (int v = 0; v < 5; v++) begin
      for (int r = 0; r < vecs[v].reps; r++) begin
        drive(1'b1, vecs[v].hi);
        drive(1'b0, vecs[v].lo);
        expq.push_back({vecs[v].exp_period, vecs[v].exp_high});
      end
    end
    drive(1'b1, 3);          // closing rise reports the last period
    drive(1'b0, 8);
    #1;
    chk("tbl_count", 32'(mq.size()), 32'(expq.size()));
    for (int i = 0; i < expq.size(); i++) begin
      if (i < mq.size()) chk($sformatf("tbl_rep%0d", i), mq[i], expq[i]);
      else chk($sformatf("tbl_rep%0d_missing", i), 32'hDEAD, expq[i]);
    end
    chk("tbl_stuck", 32'(stuck), 32'h0);

    // ---- stuck high after a rise, then recovery at period 10 ----
    do_reset();
    clear_mon();
    drive(1'b1, int'(T_OUT) + 2000);
    #1;
    chk("sh_pulses", 32'(pulses), 32'd1);
    chk("sh_stuck", 32'(stuck), 32'h1);
    chk("sh_level", 32'(stuck_level), 32'h1);
    chk("sh_high", 32'(high_cnt), 32'hFFFF);
    chk("sh_period", 32'(period_cnt), 32'h0);
    if (mq.size() > 0) chk("sh_report", mq[0], {16'h0000, 16'hFFFF});
    else chk("sh_report_missing", 32'hDEAD, {16'h0000, 16'hFFFF});
    clear_mon();
    drive(1'b0, 5);
    #1 chk("sh_cleared", 32'(stuck), 32'h0);
    drive(1'b1, 5);
    drive(1'b0, 5);
    drive(1'b1, 5);
    drive(1'b0, 5);
    drive(1'b1, 5);
    drive(1'b0, 8);
    #1;
    chk("sh_rec_count", 32'(mq.size()), 32'd2);
    if (mq.size() > 0) chk("sh_rec_report", mq[0], {16'd10, 16'd5});
    else chk("sh_rec_missing", 32'hDEAD, {16'd10, 16'd5});

    // ---- stuck low from reset ----
    do_reset();
    clear_mon();
    drive(1'b0, int'(T_OUT) - 10);
    #1;
    chk("sl_early_stuck", 32'(stuck), 32'h0);
    chk("sl_early_pulses", 32'(pulses), 32'd0);
    drive(1'b0, 20);
    #1;
    chk("sl_pulses", 32'(pulses), 32'd1);
    chk("sl_stuck", 32'(stuck), 32'h1);
    chk("sl_level", 32'(stuck_level), 32'h0);
    chk("sl_high", 32'(high_cnt), 32'h0);
    chk("sl_period", 32'(period_cnt), 32'h0);

    // ---- asynchronous reset in the middle of a high phase ----
    do_reset();
    drive(1'b1, 64);
    drive(1'b0, 192);
    drive(1'b1, 64);
    drive(1'b0, 192);
    drive(1'b1, 30);
    #1 chk("ar_pre_period", 32'(period_cnt), 32'd256);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_period", 32'(period_cnt), 32'h0);
    chk("ar_high", 32'(high_cnt), 32'h0);
    chk("ar_valid", 32'(meas_valid), 32'h0);
    chk("ar_stuck", 32'(stuck), 32'h0);
    @(negedge clk);
    drive(1'b1, 33);
    drive(1'b0, 50);
    rst_n = 1'b1;
    drive(1'b0, 142);
    clear_mon();
    drive(1'b1, 64);
    drive(1'b0, 192);
    #1 chk("ar_first_rise_silent", 32'(pulses), 32'd0);
    drive(1'b1, 64);
    drive(1'b0, 192);
    drive(1'b1, 5);
    drive(1'b0, 8);
    #1;
    chk("ar_count", 32'(mq.size()), 32'd2);
    if (mq.size() > 0) chk("ar_report", mq[0], {16'd256, 16'd64});
    else chk("ar_report_missing", 32'hDEAD, {16'd256, 16'd64});

    chk("no_back_to_back_valid", 32'(b2b), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
